// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the VGA timing generator to the pixel pipeline.
// The generator drives every signal; consumers only read them.
interface vga_timing_gen_if;
  logic [11:0] VGA_HORZ_COORD;
  logic [11:0] VGA_VERT_COORD;
  logic        VGA_ACTIVE;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output VGA_HORZ_COORD, VGA_VERT_COORD, VGA_ACTIVE, VGA_HS, VGA_VS,
           line_start, frame_start, frame_count
  );

  modport slave (
    input  VGA_HORZ_COORD, VGA_VERT_COORD, VGA_ACTIVE, VGA_HS, VGA_VS,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: pixel coordinates, delayed HS/VS/active
// aligned with the RGB pipeline, line/frame strobes and a completed-frame counter.
module vga_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 48,
  parameter int H_SYNC   = 112,
  parameter int H_BP     = 248,
  parameter int V_ACTIVE = 1024,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 38,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PIPE_DLY = 2
) (
  input  logic             clk_108,
  input  logic             rst_n,
  input  logic             en,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{act: 1'b0, hs: ~HS_POL, vs: ~VS_POL};

  logic [11:0] horz_q, horz_d;
  logic [11:0] vert_q, vert_d;
  logic [15:0] frame_count_q, frame_count_d;
  sync_t       dec;
  sync_t       sync_out;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    horz_d        = horz_q;
    vert_d        = vert_q;
    frame_count_d = frame_count_q;
    if (en) begin
      if (horz_q == H_LAST) begin
        horz_d = '0;
        if (vert_q == V_LAST) begin
          vert_d        = '0;
          frame_count_d = frame_count_q + 16'd1;
        end else begin
          vert_d = vert_q + 12'd1;
        end
      end else begin
        horz_d = horz_q + 12'd1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_108 or negedge rst_n) begin
    if (!rst_n) begin
      horz_q        <= '0;
      vert_q        <= '0;
      frame_count_q <= '0;
    end else begin
      horz_q        <= horz_d;
      vert_q        <= vert_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    dec     = SYNC_IDLE;
    dec.act = (horz_q < H_ACT) && (vert_q < V_ACT);
    dec.hs  = ((horz_q >= HS_BEG) && (horz_q < HS_END)) ? HS_POL : ~HS_POL;
    dec.vs  = ((vert_q >= VS_BEG) && (vert_q < VS_END)) ? VS_POL : ~VS_POL;
  end

  if (PIPE_DLY == 0) begin : g_no_dly
    // (0,0) decodes as active, so reset must be masked in explicitly here.
    assign sync_out = rst_n ? dec : SYNC_IDLE;
  end else begin : g_dly
    sync_t pipe_q [PIPE_DLY];
    sync_t pipe_d [PIPE_DLY];

    always_comb begin
      pipe_d = pipe_q;
      if (en) begin
        pipe_d[0] = dec;
        for (int i = 1; i < PIPE_DLY; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
    end

    // NOTE: this is a short shift register, not a RAM, so every stage is reset;
    // outputs then stay idle until real decode reaches the tap.
    always_ff @(posedge clk_108 or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE_DLY; i++) begin
          pipe_q[i] <= SYNC_IDLE;
        end
      end else begin
        pipe_q <= pipe_d;
      end
    end

    assign sync_out = pipe_q[PIPE_DLY-1];
  end

  assign vga.VGA_HORZ_COORD = horz_q;
  assign vga.VGA_VERT_COORD = vert_q;
  assign vga.VGA_ACTIVE     = sync_out.act;
  assign vga.VGA_HS         = sync_out.hs;
  assign vga.VGA_VS         = sync_out.vs;
  // Strobes mark the clock that advances past column 0; a frozen or held-in-reset
  // generator must not emit them.
  assign vga.line_start     = en && rst_n && (horz_q == 12'd0);
  assign vga.frame_start    = en && rst_n && (horz_q == 12'd0) && (vert_q == 12'd0);
  assign vga.frame_count    = frame_count_q;

endmodule
